// File: rtl/fifo_replay_ctrl_if.sv
// Stream and FIFO control bundle between the ifmap loader, the layer-1 FIFO and the PE array feed.
// master = replay controller, slave = its surroundings (loader, FIFO, PE feed).
interface fifo_replay_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  hold;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  fifo_wr_clr;
  logic                  fifo_wr_en;
  logic                  fifo_wr_inc;
  logic [DATA_WIDTH-1:0] fifo_data_in;
  logic                  fifo_rd_clr;
  logic                  fifo_rd_en;
  logic                  fifo_rd_inc;
  logic [DATA_WIDTH-1:0] fifo_data_out;

  modport master (
    input  in_valid, in_data, hold, fifo_data_out,
    output in_ready, out_valid, out_data, out_last,
           fifo_wr_clr, fifo_wr_en, fifo_wr_inc, fifo_data_in,
           fifo_rd_clr, fifo_rd_en, fifo_rd_inc
  );

  modport slave (
    output in_valid, in_data, hold, fifo_data_out,
    input  in_ready, out_valid, out_data, out_last,
           fifo_wr_clr, fifo_wr_en, fifo_wr_inc, fifo_data_in,
           fifo_rd_clr, fifo_rd_en, fifo_rd_inc
  );
endinterface

// File: rtl/fifo_replay_ctrl.sv
// Clears the layer-1 FIFO, loads one tile from the input stream, then replays it cfg_reps times.
// Writes land in the handshake cycle; replay data trails the read by 1 cycle; hold stalls read issue.
module fifo_replay_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_SIZE  = 4608,
  parameter int LEN_W      = $clog2(FIFO_SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [7:0]       cfg_reps,
  output logic             busy,
  output logic             done,
  fifo_replay_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_REPLAY, S_REWIND, S_FLUSH, S_DONE
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(FIFO_SIZE);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       reps_q, reps_d;
  logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [7:0]       rep_cnt_q, rep_cnt_d;
  logic             out_vld_q, out_last_q;

  logic [LEN_W-1:0] len_clamp;
  logic             in_rdy, wr_fire, rd_fire, rd_last, wr_clr, rd_clr, done_c;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    reps_d    = reps_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    rep_cnt_d = rep_cnt_q;
    in_rdy    = 1'b0;
    wr_fire   = 1'b0;
    rd_fire   = 1'b0;
    rd_last   = 1'b0;
    wr_clr    = 1'b0;
    rd_clr    = 1'b0;
    done_c    = 1'b0;
    len_clamp = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d     = len_clamp;
          reps_d    = cfg_reps;
          wr_cnt_d  = '0;
          rd_cnt_d  = '0;
          rep_cnt_d = '0;
          // Empty jobs complete without touching the FIFO.
          state_d   = (len_clamp == '0 || cfg_reps == 8'd0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        wr_clr  = 1'b1;
        rd_clr  = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        in_rdy  = (wr_cnt_q < len_q);
        wr_fire = in_rdy & bus.in_valid;
        if (wr_fire) begin
          wr_cnt_d = wr_cnt_q + LEN_ONE;
          if (wr_cnt_q == len_q - LEN_ONE) state_d = S_REPLAY;
        end
      end
      S_REPLAY: begin
        rd_fire = !bus.hold && (rd_cnt_q < len_q);
        if (rd_fire) begin
          rd_cnt_d = rd_cnt_q + LEN_ONE;
          if (rd_cnt_q == len_q - LEN_ONE) begin
            rd_last = 1'b1;
            state_d = (rep_cnt_q < reps_q - 8'd1) ? S_REWIND : S_FLUSH;
          end
        end
      end
      S_REWIND: begin
        rd_clr    = 1'b1;
        rd_cnt_d  = '0;
        rep_cnt_d = rep_cnt_q + 8'd1;
        state_d   = S_REPLAY;
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      reps_q     <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      rep_cnt_q  <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      reps_q     <= reps_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      out_vld_q  <= rd_fire;
      out_last_q <= rd_last;
    end
  end

  // Gated by rst_n so every output already reads zero before the first reset edge.
  assign busy             = rst_n && (state_q != S_IDLE);
  assign done             = rst_n && done_c;
  assign bus.in_ready     = rst_n && in_rdy;
  assign bus.fifo_wr_clr  = rst_n && wr_clr;
  assign bus.fifo_wr_en   = rst_n && wr_fire;
  assign bus.fifo_wr_inc  = rst_n && wr_fire;
  assign bus.fifo_data_in = rst_n ? bus.in_data : '0;
  assign bus.fifo_rd_clr  = rst_n && rd_clr;
  assign bus.fifo_rd_en   = rst_n && rd_fire;
  assign bus.fifo_rd_inc  = rst_n && rd_fire;
  assign bus.out_valid    = rst_n && out_vld_q;
  assign bus.out_last     = rst_n && out_last_q;
  assign bus.out_data     = rst_n ? bus.fifo_data_out : '0;

endmodule

// File: tb/tb_fifo_replay_ctrl.sv
// Bench for fifo_replay_ctrl: a behavioural FIFO beside the DUT, randomized jobs, and a tile-level
// expectation (words repeated reps times, last flag every len words) built from the job parameters.
module tb_fifo_replay_ctrl;
  localparam int DW = 16;
  localparam int FS = 4608;
  localparam int LW = $clog2(FS + 1);
  localparam int PW = $clog2(FS);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic [7:0]    cfg_reps = '0;
  logic          busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_replay_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  fifo_replay_ctrl #(.DATA_WIDTH(DW), .FIFO_SIZE(FS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .cfg_len (cfg_len),
    .cfg_reps(cfg_reps),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Layer-1 FIFO: same-cycle write, 1-cycle registered read, output zero when not reading.
  logic [DW-1:0] mem [0:(1<<PW)-1];
  logic [PW-1:0] wptr = '0;
  logic [PW-1:0] rptr = '0;
  logic [DW-1:0] dout = '0;
  int            max_wptr = -1;
  int            max_rptr = -1;

  assign bus.fifo_data_out = dout;

  always @(posedge clk) begin
    if (bus.fifo_wr_clr) begin
      wptr     <= '0;
      max_wptr <= -1;
      max_rptr <= -1;
    end else begin
      if (bus.fifo_wr_en) begin
        mem[wptr] <= bus.fifo_data_in;
        if (int'(wptr) > max_wptr) max_wptr <= int'(wptr);
      end
      if (bus.fifo_wr_inc) wptr <= wptr + 1'b1;
    end
    if (bus.fifo_rd_clr) begin
      rptr <= '0;
      dout <= '0;
    end else begin
      if (bus.fifo_rd_en) begin
        dout <= mem[rptr];
        if (int'(rptr) > max_rptr && !bus.fifo_wr_clr) max_rptr <= int'(rptr);
      end else begin
        dout <= '0;
      end
      if (bus.fifo_rd_inc) rptr <= rptr + 1'b1;
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // vmode: 0 always valid, 1 valid every other cycle, 2 random valid.
  // hmode: 0 no hold, 1 one 3-cycle hold after two outputs, 2 random hold.
  task automatic run_job(input int clen, input int creps, input int vmode, input int hmode,
                         input int abort_at, input bit seq);
    int            len;
    logic [DW-1:0] words[$];
    logic [DW-1:0] wr_q[$];
    logic [DW-1:0] out_q[$];
    int            last_idx[$];
    int idx = 0, done_cyc = -1, last_rd = -1, first_out = -1, last_out = -1;
    int rd_n = 0, wclr_n = 0, rew_n = 0, rdy_n = 0, hold_viol = 0, hold_n = 0, bad;
    int busy_at_done = 0, budget;
    bit prev_hold = 1'b0;

    len = (clen > FS) ? FS : clen;
    for (int i = 0; i < len; i++)
      words.push_back(seq ? DW'(i + 1) : DW'($urandom_range(0, 65535)));
    budget = 4 * len * (creps + 1) + 60;

    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #1;
      start    = (c == 0);
      cfg_len  = LW'(clen);
      cfg_reps = 8'(creps);
      if (idx < len) begin
        case (vmode)
          0:       bus.in_valid = 1'b1;
          1:       bus.in_valid = (c % 2 == 0);
          default: bus.in_valid = 1'($urandom_range(0, 1));
        endcase
        bus.in_data = words[idx];
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
      end
      if (hmode == 1 && hold_n < 3 && out_q.size() >= 2) begin
        bus.hold = 1'b1;
        hold_n++;
      end else if (hmode == 2) begin
        bus.hold = ($urandom_range(0, 3) == 0);
      end else begin
        bus.hold = 1'b0;
      end

      @(negedge clk);
      if (bus.in_valid && bus.in_ready) idx++;
      if (bus.in_ready) rdy_n++;
      if (bus.fifo_wr_en) wr_q.push_back(bus.fifo_data_in);
      if (bus.fifo_wr_clr) wclr_n++;
      if (bus.fifo_rd_clr && !bus.fifo_wr_clr) rew_n++;
      if (bus.fifo_rd_en) begin
        rd_n++;
        last_rd = c;
      end
      if (bus.out_valid) begin
        if (prev_hold) hold_viol++;
        if (first_out < 0) first_out = c;
        last_out = c;
        if (bus.out_last) last_idx.push_back(out_q.size());
        out_q.push_back(bus.out_data);
      end
      prev_hold = bus.hold;
      if (done) begin
        done_cyc     = c;
        busy_at_done = int'(busy);
        break;
      end
      if (abort_at > 0 && out_q.size() >= abort_at) break;
    end
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.hold     = 1'b0;

    if (abort_at > 0) begin
      check("abort_reached", longint'(out_q.size() >= abort_at), 1);
      return;
    end
    if (done_cyc < 0) begin
      check("timeout_waiting_done", 0, 1);
      return;
    end
    check("busy_in_done", busy_at_done, 1);

    if (len == 0 || creps == 0) begin
      check("empty_done_latency", done_cyc, 1);
      check("empty_fifo_activity", wr_q.size() + rd_n + wclr_n + rew_n, 0);
      check("empty_in_ready", rdy_n, 0);
      check("empty_out_count", out_q.size(), 0);
      return;
    end

    check("wr_count", wr_q.size(), len);
    bad = 0;
    foreach (wr_q[i]) if (i < len && wr_q[i] !== words[i]) bad++;
    check("wr_data_mismatches", bad, 0);
    check("wr_clr_pulses", wclr_n, 1);
    check("rd_count", rd_n, len * creps);
    check("rewind_pulses", rew_n, creps - 1);
    check("out_count", out_q.size(), len * creps);
    bad = 0;
    foreach (out_q[k]) if (out_q[k] !== words[k % len]) bad++;
    check("out_data_mismatches", bad, 0);
    check("out_first_word", out_q.size() > 0 ? longint'(out_q[0]) : -1, words[0]);
    check("out_last_count", last_idx.size(), creps);
    bad = 0;
    foreach (last_idx[k]) if (last_idx[k] != (k + 1) * len - 1) bad++;
    check("out_last_position", bad, 0);
    check("out_during_hold", hold_viol, 0);
    check("done_after_last_read", done_cyc - last_rd, 2);
    if (hmode == 0)
      check("out_span_cycles", last_out - first_out, len * creps + creps - 2);
    if (clen > FS) begin
      check("clamp_max_wptr", max_wptr, FS - 1);
      check("clamp_max_rptr", max_rptr, FS - 1);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h5A5A;
    bus.hold     = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl_outputs", {busy, done, bus.in_ready, bus.out_valid, bus.out_last,
                               bus.fifo_wr_clr, bus.fifo_wr_en, bus.fifo_wr_inc,
                               bus.fifo_rd_clr, bus.fifo_rd_en, bus.fifo_rd_inc}, 0);
    check("rst_fifo_data_in", bus.fifo_data_in, 0);
    check("rst_out_data", bus.out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_in_ready", bus.in_ready, 0);

    run_job(4, 1, 0, 0, 0, 1'b1);
    run_job(3, 3, 0, 0, 0, 1'b0);
    run_job(5, 2, 1, 1, 0, 1'b0);
    run_job(5000, 1, 0, 2, 0, 1'b0);
    run_job(0, 3, 0, 0, 0, 1'b0);
    run_job(5, 0, 0, 0, 0, 1'b0);
    for (int j = 0; j < 4; j++)
      run_job($urandom_range(1, 40), $urandom_range(1, 4), $urandom_range(0, 2),
              2 * $urandom_range(0, 1), 0, 1'b0);

    // Abandon a job mid-replay, then run a fresh short one.
    run_job(8, 3, 0, 0, 5, 1'b0);
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    bus.in_data = 16'hBEEF;
    @(negedge clk);
    check("midjob_rst_outputs", {busy, done, bus.in_ready, bus.out_valid, bus.out_last,
                                 bus.fifo_wr_clr, bus.fifo_wr_en, bus.fifo_rd_clr,
                                 bus.fifo_rd_en}, 0);
    check("midjob_rst_out_data", bus.out_data, 0);
    check("midjob_rst_data_in", bus.fifo_data_in, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    run_job(2, 1, 0, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
